// File: rtl/aes_mixcol_engine_if.sv
// Valid/ready handshake bundle for aes_mixcol_engine (upstream state in, transformed state out).
// AES_MIXCOL_BYPASS_EN adds the per-transaction bypass request.
interface aes_mixcol_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inverse;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
`ifdef AES_MIXCOL_BYPASS_EN
  logic         bypass;

  modport master (
    output in_valid, in_state, in_inverse, out_ready, bypass,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_inverse, out_ready, bypass,
    output in_ready, out_valid, out_state, busy
  );
`else
  modport master (
    output in_valid, in_state, in_inverse, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_inverse, out_ready,
    output in_ready, out_valid, out_state, busy
  );
`endif
endinterface

// File: rtl/aes_mixcol_engine.sv
// Sequential MixColumns / InvMixColumns over a 128-bit AES state, COLS_PER_CYCLE columns per clock.
// Optional macro AES_MIXCOL_BYPASS_EN: bypass request skips the transform (final AES round).
//
// state | meaning
// IDLE  | in_ready high, waiting for a state to accept
// BUSY  | transforming columns in place, col_cnt_q selects the first column of this cycle
// DONE  | result held on out_state with out_valid until out_ready
module aes_mixcol_engine #(
  parameter int         COLS_PER_CYCLE = 1,
  parameter logic [7:0] POLY           = 8'h1B
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_mixcol_engine_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] COL_STEP = 3'(COLS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] work_q, work_d;
  logic         mode_q, mode_d;

  logic         accept;
  logic [2:0]   col_sum;
  logic         last_step;
  logic [1:0]   col_idx;
  logic [31:0]  col_cur [4];
  logic [31:0]  col_new [4];
  logic [127:0] work_mixed;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] y  [4];
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      m2[r] = xtime(a[r]);
      m4[r] = xtime(m2[r]);
      m8[r] = xtime(m4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      if (!inv) begin
        y[r] = m2[r] ^ (m2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
      end else begin
        y[r] = (m8[r] ^ m4[r] ^ m2[r])
             ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ a[(r+1)%4])
             ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ a[(r+2)%4])
             ^ (m8[(r+3)%4] ^ a[(r+3)%4]);
      end
    end
    return {y[0], y[1], y[2], y[3]};
  endfunction

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign col_sum   = {1'b0, col_cnt_q} + COL_STEP;
  assign last_step = col_sum[2];

  // Only the columns selected by col_cnt_q are rewritten; the rest pass through.
  always_comb begin
    col_idx = '0;
    for (int i = 0; i < 4; i++) begin
      col_cur[i] = work_q[127-32*i -: 32];
    end
    col_new = col_cur;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_idx          = col_cnt_q + 2'(j);
      col_new[col_idx] = mix_col(col_cur[col_idx], mode_q);
    end
    work_mixed = {col_new[0], col_new[1], col_new[2], col_new[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      work_q    <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
      mode_q    <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    mode_d    = mode_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          work_d    = bus.in_state;
          mode_d    = bus.in_inverse;
          col_cnt_d = '0;
          state_d   = BUSY;
`ifdef AES_MIXCOL_BYPASS_EN
          if (bus.bypass) state_d = DONE;
`endif
        end
      end
      BUSY: begin
        work_d    = work_mixed;
        col_cnt_d = col_sum[1:0];
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outside DONE the output bus reads zero so no partial result is visible.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q == BUSY) || (state_q == DONE);
    bus.out_state = (state_q == DONE) ? work_q : '0;
  end

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Randomised bench for aes_mixcol_engine: three instances (1, 4, 2 columns per cycle) against a
// GF(2^8) reference model; optional bypass path checked when AES_MIXCOL_BYPASS_EN is defined.
module tb_aes_mixcol_engine;

  logic clk;
  logic rst_n;

  logic         in_valid   [3];
  logic [127:0] in_state   [3];
  logic         in_inverse [3];
  logic         out_ready  [3];
`ifdef AES_MIXCOL_BYPASS_EN
  logic         bypass     [3];
`endif

  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic [127:0] out_state_w [3];
  logic         busy_w      [3];

  int total = 0;
  int bad   = 0;

  int           cyc = 0;
  bit           pending   [3];
  int           acc_cyc   [3];
  int           exp_edges [3];
  int           xfer      [3];
  logic [127:0] exp_val   [3];

  localparam logic [127:0] V_FWD_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] V_INV_IN  = 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8;
  localparam logic [127:0] V_INV_OUT = 128'hdb135345f20a225cd4d4d4d52d26314c;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CPC = (k == 0) ? 1 : (k == 1) ? 4 : 2;
    aes_mixcol_engine_if ifc ();
    assign ifc.in_valid   = in_valid[k];
    assign ifc.in_state   = in_state[k];
    assign ifc.in_inverse = in_inverse[k];
    assign ifc.out_ready  = out_ready[k];
`ifdef AES_MIXCOL_BYPASS_EN
    assign ifc.bypass     = bypass[k];
`endif
    assign in_ready_w[k]  = ifc.in_ready;
    assign out_valid_w[k] = ifc.out_valid;
    assign out_state_w[k] = ifc.out_state;
    assign busy_w[k]      = ifc.busy;

    aes_mixcol_engine #(.COLS_PER_CYCLE(CPC), .POLY(8'h1B)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int cols_per_cycle(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 2;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [127:0] o;
    logic [7:0]   acc;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
          acc = acc ^ gmul(coef[i], s[127-32*c-8*((r+i)%4) -: 8]);
        end
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected result and timing are recorded at the acceptance edge; the engine holds one job at a time.
  initial begin
    logic byp;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) pending[k] = 1'b0;
      end else begin
        cyc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
          if (out_valid_w[k] && out_ready[k]) begin
            pending[k] = 1'b0;
            xfer[k]    = xfer[k] + 1;
          end else if (in_valid[k] && in_ready_w[k]) begin
`ifdef AES_MIXCOL_BYPASS_EN
            byp = bypass[k];
`else
            byp = 1'b0;
`endif
            pending[k]   = 1'b1;
            acc_cyc[k]   = cyc;
            exp_edges[k] = byp ? 1 : (4 / cols_per_cycle(k)) + 1;
            exp_val[k]   = byp ? in_state[k] : ref_mix(in_state[k], in_inverse[k]);
          end
        end
      end
    end
  end

  // Edges are counted including the acceptance edge itself.
  initial begin
    int elapsed;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 3; k++) begin
          if (!pending[k]) begin
            check($sformatf("idle_ctl%0d {in_ready,busy,out_valid}", k),
                  {in_ready_w[k], busy_w[k], out_valid_w[k]}, 3'b100);
          end else begin
            elapsed = cyc - acc_cyc[k] + 1;
            if (elapsed < exp_edges[k]) begin
              check($sformatf("busy_ctl%0d {in_ready,busy,out_valid}", k),
                    {in_ready_w[k], busy_w[k], out_valid_w[k]}, 3'b010);
            end else begin
              check($sformatf("done_ctl%0d {in_ready,busy,out_valid}", k),
                    {in_ready_w[k], busy_w[k], out_valid_w[k]}, 3'b011);
              check($sformatf("done_data%0d", k), out_state_w[k], exp_val[k]);
            end
          end
        end
      end
    end
  end

  // Inputs are scrambled right after acceptance to show the engine ignores them from then on.
  task automatic run_txn(input int k, input logic [127:0] s, input logic inv, output logic [127:0] res);
    int n;
    bit got;
    res = '0;
    @(negedge clk);
    in_valid[k]   = 1'b1;
    in_state[k]   = s;
    in_inverse[k] = inv;
    n = 0;
    while (!in_ready_w[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_wait%0d", k), 128'(n < 20), 128'(1));
    @(posedge clk);
    #1;
    in_valid[k]   = 1'b0;
    in_state[k]   = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_inverse[k] = 1'($urandom());
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (out_valid_w[k]) begin
        got = 1'b1;
        res = out_state_w[k];
      end
      n++;
    end
    check($sformatf("result_wait%0d", k), 128'(got), 128'(1));
    if (out_ready[k]) @(posedge clk);
  endtask

  initial begin
    logic [127:0] r;
    logic [127:0] f;
    logic [127:0] s;
    int           x0;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]   = 1'b0;
      in_state[k]   = '0;
      in_inverse[k] = 1'b0;
      out_ready[k]  = 1'b1;
`ifdef AES_MIXCOL_BYPASS_EN
      bypass[k]     = 1'b0;
`endif
    end

    check("model_gmul_57x83", 128'(gmul(8'h57, 8'h83)), 128'(8'hc1));
    check("model_fwd", ref_mix(V_FWD_IN, 1'b0), V_FWD_OUT);
    check("model_inv", ref_mix(V_INV_IN, 1'b1), V_INV_OUT);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_in_ready%0d", k),  128'(in_ready_w[k]),  128'(1));
      check($sformatf("rst_out_valid%0d", k), 128'(out_valid_w[k]), 128'(0));
      check($sformatf("rst_out_state%0d", k), out_state_w[k], '0);
      check($sformatf("rst_busy%0d", k),      128'(busy_w[k]),      128'(0));
    end
    rst_n = 1'b1;

    run_txn(0, V_FWD_IN, 1'b0, r);
    check("fwd_cpc1", r, V_FWD_OUT);
    run_txn(1, V_INV_IN, 1'b1, r);
    check("inv_cpc4", r, V_INV_OUT);

    out_ready[2] = 1'b0;
    run_txn(2, V_FWD_IN, 1'b0, r);
    check("bp_first", r, V_FWD_OUT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid[2] = 1'($urandom());
      in_state[2] = {$urandom(), $urandom(), $urandom(), $urandom()};
      check("bp_stable", out_state_w[2], V_FWD_OUT);
    end
    x0 = xfer[2];
    @(negedge clk);
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_one_transfer", 128'(xfer[2] - x0), 128'(1));

    // Abort in the second BUSY cycle of the one-column instance.
    @(negedge clk);
    in_valid[0]   = 1'b1;
    in_state[0]   = V_FWD_IN;
    in_inverse[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_busy", 128'(busy_w[0]), 128'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid_w[0]), 128'(0));
    check("mid_rst_out_state", out_state_w[0], '0);
    check("mid_rst_in_ready",  128'(in_ready_w[0]),  128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(0, V_FWD_IN, 1'b0, r);
    check("post_rst_fwd", r, V_FWD_OUT);

    for (int i = 0; i < 100; i++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_txn(2, s, 1'b0, f);
      run_txn(2, f, 1'b1, r);
      check($sformatf("roundtrip%0d", i), r, s);
    end

    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++) begin
        s = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_txn(k, s, 1'($urandom()), r);
      end
    end

`ifdef AES_MIXCOL_BYPASS_EN
    bypass[1] = 1'b1;
    run_txn(1, 128'h00112233445566778899aabbccddeeff, 1'b0, r);
    bypass[1] = 1'b0;
    check("bypass", r, 128'h00112233445566778899aabbccddeeff);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
